// File: rtl/banked_regfile_pkg.sv
// Shared types and helpers for the banked register file: default width, bank encodings,
// sequencer states, and the architectural-to-physical index function.
package regfile_pkg;

   localparam int DATA_W_DEF = 32;

   localparam int BANK_USR = 0;
   localparam int BANK_FIQ = 1;
   localparam int BANK_IRQ = 2;
   localparam int BANK_SVC = 3;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   // Unbanked registers sit at the bottom; each bank owns a contiguous slice above them.
   function automatic int unsigned phys_idx(input int unsigned addr,
                                            input int unsigned bank,
                                            input int unsigned nregs,
                                            input int unsigned nbank,
                                            input int unsigned banked_lo);
      int unsigned b;
      b = (bank >= nbank) ? 0 : bank;
      if (addr < banked_lo) return addr;
      return banked_lo + b * (nregs - banked_lo) + (addr - banked_lo);
   endfunction

endpackage

// File: rtl/banked_regfile_if.sv
// Operand-read / writeback bus of the banked register file.
// The master side is the pipeline (decode + writeback), the slave side is the register file.
interface banked_regfile_if #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 16,
   parameter int NREAD  = 3,
   parameter int NBANK  = 4
);
   localparam int AW = $clog2(NREGS);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

   logic [BW-1:0]           mode;
   logic [NREAD*AW-1:0]     rd_addr;
   logic [NREAD*DATA_W-1:0] rd_data;
   logic                    wr0_req;
   logic [AW-1:0]           wr0_addr;
   logic [BW-1:0]           wr0_bank;
   logic [DATA_W-1:0]       wr0_data;
   logic                    wr1_req;
   logic [AW-1:0]           wr1_addr;
   logic [BW-1:0]           wr1_bank;
   logic [DATA_W-1:0]       wr1_data;
   logic [DATA_W-1:0]       pc_out;
   logic                    busy;

   modport master (
      output mode, rd_addr, wr0_req, wr0_addr, wr0_bank, wr0_data,
             wr1_req, wr1_addr, wr1_bank, wr1_data,
      input  rd_data, pc_out, busy
   );

   modport slave (
      input  mode, rd_addr, wr0_req, wr0_addr, wr0_bank, wr0_data,
             wr1_req, wr1_addr, wr1_bank, wr1_data,
      output rd_data, pc_out, busy
   );

endinterface

// File: rtl/banked_regfile_phys_map.sv
// Combinational architectural (address, bank) to physical entry index translation.
module regfile_phys_map
   import regfile_pkg::*;
#(
   parameter int NREGS     = 16,
   parameter int NBANK     = 4,
   parameter int BANKED_LO = 13,
   parameter int AW        = 4,
   parameter int BW        = 2,
   parameter int PW        = 5
) (
   input  logic [AW-1:0] addr,
   input  logic [BW-1:0] bank,
   output logic [PW-1:0] phys
);

   assign phys = PW'(phys_idx(32'(addr), 32'(bank), NREGS, NBANK, BANKED_LO));

endmodule

// File: rtl/banked_regfile.sv
// Multi-port register file with per-mode banking of the upper registers and a post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module banked_regfile
   import regfile_pkg::*;
#(
   parameter int              DATA_W    = DATA_W_DEF,
   parameter int              NREGS     = 16,
   parameter int              NREAD     = 3,
   parameter int              NBANK     = 4,
   parameter int              BANKED_LO = 13,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input logic              clk,
   input logic              rst,
   banked_regfile_if.slave  bus
);

   localparam int AW   = $clog2(NREGS);
   localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int PHYS = BANKED_LO + NBANK * (NREGS - BANKED_LO);
   localparam int PW   = (PHYS > 1) ? $clog2(PHYS) : 1;

   rf_state_t         state, state_n;
   logic [PW-1:0]     clr_idx, clr_idx_n;
   logic              busy;
   logic              we0, we1;
   logic [PW-1:0]     wr0_phys, wr1_phys, pc_phys;
   logic [PW-1:0]     rd_phys [NREAD];
   logic [DATA_W-1:0] mem [PHYS];
   logic [NREAD*DATA_W-1:0] rd_data_c;
   logic [DATA_W-1:0] pc_c;

   assign busy = (state == CLEAR);
   assign we0  = bus.wr0_req & ~busy;
   assign we1  = bus.wr1_req & ~busy;

   regfile_phys_map #(.NREGS(NREGS), .NBANK(NBANK), .BANKED_LO(BANKED_LO),
                      .AW(AW), .BW(BW), .PW(PW))
      u_map_wr0 (.addr(bus.wr0_addr), .bank(bus.wr0_bank), .phys(wr0_phys));

   regfile_phys_map #(.NREGS(NREGS), .NBANK(NBANK), .BANKED_LO(BANKED_LO),
                      .AW(AW), .BW(BW), .PW(PW))
      u_map_wr1 (.addr(bus.wr1_addr), .bank(bus.wr1_bank), .phys(wr1_phys));

   regfile_phys_map #(.NREGS(NREGS), .NBANK(NBANK), .BANKED_LO(BANKED_LO),
                      .AW(AW), .BW(BW), .PW(PW))
      u_map_pc (.addr(AW'(NREGS - 1)), .bank(bus.mode), .phys(pc_phys));

   for (genvar i = 0; i < NREAD; i++) begin : g_rd_map
      regfile_phys_map #(.NREGS(NREGS), .NBANK(NBANK), .BANKED_LO(BANKED_LO),
                         .AW(AW), .BW(BW), .PW(PW))
         u_map_rd (.addr(bus.rd_addr[i*AW +: AW]), .bank(bus.mode), .phys(rd_phys[i]));
   end

   // Clear sequencer: one physical entry per cycle, then hand over to normal operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_n;
         clr_idx <= clr_idx_n;
      end
   end

   always_comb begin
      state_n   = state;
      clr_idx_n = clr_idx;
      case (state)
         CLEAR: begin
            clr_idx_n = clr_idx + 1'b1;
            if (clr_idx == PW'(PHYS - 1)) begin
               state_n   = RUN;
               clr_idx_n = '0;
            end
         end
         RUN:     state_n = RUN;
         default: state_n = CLEAR;
      endcase
   end

   // Port 1 is written last so it wins a same-entry collision.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_idx] <= INIT_VAL;
      end else begin
         if (we0) mem[wr0_phys] <= bus.wr0_data;
         if (we1) mem[wr1_phys] <= bus.wr1_data;
      end
   end

   function automatic logic [DATA_W-1:0] read_val(input logic [PW-1:0] p);
      logic [DATA_W-1:0] v;
      v = mem[p];
`ifdef REGFILE_BYPASS_EN
      if (we1 && (wr1_phys == p))      v = bus.wr1_data;
      else if (we0 && (wr0_phys == p)) v = bus.wr0_data;
`endif
      if (busy) v = '0;
      return v;
   endfunction

   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < NREAD; i++) rd_data_c[i*DATA_W +: DATA_W] = read_val(rd_phys[i]);
      pc_c = read_val(pc_phys);
   end

   assign bus.rd_data = rd_data_c;
   assign bus.pc_out  = pc_c;
   assign bus.busy    = busy;

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Parametrised successor to the single-bank 16-entry register file: N read ports, two write ports (ALU writeback, load writeback), and per-mode banking of the upper architectural registers (ARM-style r13/r14 banking).
- Sits in the decode/writeback path of the core; the decode stage reads operands, and the writeback stage writes results.
- Adds a post-reset clear sequencer that initialises every physical entry and signals busy to the pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 16, architectural registers; address width AW = clog2(NREGS).
- NREAD, 3, read port count.
- NBANK, 4, mode banks; bank select width BW = clog2(NBANK), minimum 1.
- BANKED_LO, 13, first banked architectural register; registers BANKED_LO..NREGS-1 are banked.
- INIT_VAL, 0, value written to every physical entry during clear.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mode  in  BW  bank used by all read ports
- rd_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
- rd_data  out  NREAD*DATA_W  packed read data, port i at [i*DATA_W +: DATA_W]
- wr0_req  in  1  write port 0 enable (ALU)
- wr0_addr  in  AW  port 0 architectural address
- wr0_bank  in  BW  port 0 bank
- wr0_data  in  DATA_W  port 0 data
- wr1_req, wr1_addr, wr1_bank, wr1_data  in  1/AW/BW/DATA_W  write port 1 (load); same meaning as port 0
- pc_out  out  DATA_W  architectural register NREGS-1 in bank mode, combinational
- busy  out  1  clear sequence in progress

Behaviour:
- Physical entries: PHYS = BANKED_LO + NBANK*(NREGS-BANKED_LO).
- Address mapping:
  - Architectural address a < BANKED_LO maps to physical a.
  - Otherwise maps to BANKED_LO + b*(NREGS-BANKED_LO) + (a-BANKED_LO), where b is the relevant bank.
  - A bank value >= NBANK maps to bank 0.
- FSM states: CLEAR, RUN.
  - rst=1 at a clock edge: state<=CLEAR, clear index<=0, busy=1 next cycle. Reset asserted mid-clear restarts the sweep at index 0.
  - CLEAR: each cycle writes INIT_VAL to physical[index] and increments the index. When the write lands at index PHYS-1, state<=RUN and busy<=0. The sweep takes exactly PHYS cycles after rst deasserts.
  - RUN: writes are accepted. busy stays 0.
- While busy=1:
  - wr0_req and wr1_req are ignored.
  - rd_data and pc_out return 0.
- Writes are registered and land at the posedge; read is combinational from the array.
- Both ports writing the same physical entry in one cycle: port 1 wins. Different entries: both are written.
- The same architectural address in different banks counts as a different entry for unbanked-vs-banked purposes. Only a physical-index match counts as a collision.
- Read latency is 0 cycles (combinational). A write is visible to the array on the cycle after its request.
- Forwarding is defined under Optional Feature only.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port or pc_out whose physical index matches an active write in the same cycle returns that write's data.
  - If both ports match, port 1's data is returned.
  - No forwarding while busy.
- Undefined: reads return the pre-write array contents. The pipeline inserts a bubble instead.

Decomposition:
- Package regfile_pkg:
  - Default DATA_W.
  - Mode/bank encoding localparams: BANK_USR=0, BANK_FIQ=1, BANK_IRQ=2, BANK_SVC=3.
  - State enum CLEAR/RUN.
  - Function phys_idx(addr, bank), used by both the RTL and the bench model.
- Sub-module regfile_phys_map: combinational architectural-to-physical mapping, instantiated once per read port, once per write port and once for pc_out.

Test Plan:
- Clear: pulse rst for 1 cycle. busy is 1 for exactly PHYS=25 cycles (defaults), then 0. Every address in every bank then reads 0.
- Banking: in RUN, write r13=0x1111 with bank 0 and r13=0x2222 with bank 3, plus r5=0x55 with bank 3. Then:
  - mode=0 reads r13=0x1111; mode=3 reads r13=0x2222.
  - r5 reads 0x55 under both modes.
  - mode=5 (if BW allows) reads the bank 0 values.
- Collision: wr0 and wr1 both target r2 in one cycle, data 0xAAAA/0xBBBB. The next cycle r2 reads 0xBBBB.
- Bypass: write r7=0xCAFE while reading r7 on all NREAD ports in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data returns 0xCAFE that cycle.
  - Without: returns the old value, then 0xCAFE the next cycle.
- Reset mid-clear: assert rst at clear index 10. The sweep restarts and busy lasts PHYS cycles from the new deassertion. A write requested during busy is lost; the target reads 0 after clear.
- pc_out: write r15=0x8000 with bank 1 and set mode=1. pc_out is 0x8000; with mode=0, pc_out reads 0.
